// File: rtl/sample_team_proj_core.sv
// Walking one-hot GPIO sequencer: advances one bit every prescaler milliseconds,
// pauses on stop, and pulses done when the pattern wraps from the top bit back to bit 0.
module sample_team_proj_core #(
  parameter int unsigned CLK_PER_MS = 10000,
  parameter int unsigned NGPIO      = 34
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             stop,
  input  logic [13:0]      prescaler,
  output logic [NGPIO-1:0] gpio,
  output logic             done,
  output logic             busy
);

  localparam int unsigned PW = 14;
  localparam int unsigned CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLK_PER_MS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CW-1:0]    r_cyc;
  logic [CW-1:0]    w_cyc_nxt;
  logic [PW-1:0]    r_ms;
  logic [PW-1:0]    w_ms_nxt;
  logic [PW-1:0]    r_period;
  logic [PW-1:0]    w_period_nxt;
  logic [NGPIO-1:0] r_gpio;
  logic [NGPIO-1:0] w_gpio_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_busy;
  logic             w_busy_nxt;

  logic w_active;
  logic w_count;
  logic w_wrap;
  logic w_step;
  logic w_pre_zero;

  // Counting happens only on enabled, un-stopped edges, so paused cycles are the only ones lost.
  assign w_active   = (r_state != S_IDLE);
  assign w_count    = w_active && en && !stop;
  assign w_wrap     = (r_cyc == CYC_LAST);
  assign w_step     = w_count && w_wrap && (r_ms == (r_period - PW'(1)));
  assign w_pre_zero = (prescaler == '0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: en=0 wins over stop and over a due step.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (en && !w_pre_zero) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!en)                     w_state_nxt = S_IDLE;
        else if (stop)               w_state_nxt = S_PAUSE;
        else if (w_step && w_pre_zero) w_state_nxt = S_IDLE;
      end
      S_PAUSE: begin
        if (!en) begin
          w_state_nxt = S_IDLE;
        end else if (!stop) begin
          w_state_nxt = (w_step && w_pre_zero) ? S_IDLE : S_RUN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next datapath values; a step relatches prescaler so changes apply from the next bit on.
  always_comb begin
    w_cyc_nxt    = r_cyc;
    w_ms_nxt     = r_ms;
    w_period_nxt = r_period;
    w_gpio_nxt   = r_gpio;
    w_done_nxt   = 1'b0;
    if (r_state == S_IDLE) begin
      w_cyc_nxt    = '0;
      w_ms_nxt     = '0;
      w_period_nxt = '0;
      w_gpio_nxt   = '0;
      if (en && !w_pre_zero) begin
        w_gpio_nxt   = NGPIO'(1);
        w_period_nxt = prescaler;
      end
    end else if (!en) begin
      w_cyc_nxt    = '0;
      w_ms_nxt     = '0;
      w_period_nxt = '0;
      w_gpio_nxt   = '0;
    end else if (w_count) begin
      if (!w_wrap) begin
        w_cyc_nxt = r_cyc + CW'(1);
      end else begin
        w_cyc_nxt = '0;
        if (!w_step) begin
          w_ms_nxt = r_ms + PW'(1);
        end else begin
          w_ms_nxt     = '0;
          w_period_nxt = prescaler;
          if (w_pre_zero) begin
            w_gpio_nxt = '0;
          end else begin
            w_gpio_nxt = {r_gpio[NGPIO-2:0], r_gpio[NGPIO-1]};
            w_done_nxt = r_gpio[NGPIO-1];
          end
        end
      end
    end
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cyc    <= '0;
      r_ms     <= '0;
      r_period <= '0;
      r_gpio   <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_cyc    <= w_cyc_nxt;
      r_ms     <= w_ms_nxt;
      r_period <= w_period_nxt;
      r_gpio   <= w_gpio_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign gpio = r_gpio;
  assign done = r_done;
  assign busy = r_busy;

endmodule

// File: tb/tb_sample_team_proj_core.sv
// Scoreboard bench for sample_team_proj_core: expected output events are queued by the
// stimulus and matched by a negedge monitor whenever gpio/busy change or done pulses.
module tb_sample_team_proj_core;

  localparam int unsigned NG  = 34;
  localparam int unsigned CPM = 4;

  typedef struct packed {
    int          cyc;
    logic [NG-1:0] gpio;
    logic        done;
    logic        busy;
  } ev_t;

  logic          clk;
  logic          nrst;
  logic          en;
  logic          stop;
  logic [13:0]   prescaler;
  logic [NG-1:0] gpio;
  logic          done;
  logic          busy;
  logic          en2;
  logic          stop2;
  logic [13:0]   prescaler2;
  logic [NG-1:0] gpio2;
  logic          done2;
  logic          busy2;

  int tb_cyc = 0;
  int n_vec  = 0;
  int n_err  = 0;

  ev_t         sb_q[$];
  string       chk_name_q[$];
  logic [63:0] chk_act_q[$];
  logic [63:0] chk_exp_q[$];

  sample_team_proj_core #(.CLK_PER_MS(CPM), .NGPIO(NG)) u_dut (
    .clk(clk), .nrst(nrst), .en(en), .stop(stop), .prescaler(prescaler),
    .gpio(gpio), .done(done), .busy(busy)
  );

  sample_team_proj_core u_dut_ms (
    .clk(clk), .nrst(nrst), .en(en2), .stop(stop2), .prescaler(prescaler2),
    .gpio(gpio2), .done(done2), .busy(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, cycle=%0d", tb_cyc);
    $fatal(1, "timeout");
  end

  function automatic logic [NG-1:0] oh(input int k);
    oh = NG'(1) << k;
  endfunction

  task automatic push(input int c, input logic [NG-1:0] g, input logic d, input logic b);
    ev_t x;
    x.cyc  = c;
    x.gpio = g;
    x.done = d;
    x.busy = b;
    sb_q.push_back(x);
  endtask

  // Expected walk with prescaler=1: bit k appears 4k cycles after entry.
  task automatic push_sweep(input int e, input int nbits);
    for (int k = 0; k < nbits; k++) push(e + 4 * k, oh(k), 1'b0, 1'b1);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_name_q.push_back(name);
    chk_act_q.push_back(act);
    chk_exp_q.push_back(exp);
  endtask

  task automatic wait_cyc(input int c);
    while (tb_cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: sole owner of the comparison counters.
  logic [NG-1:0] m_pg = '0;
  logic          m_pb = 1'b0;
  always @(negedge clk) begin
    ev_t x;
    if (gpio !== m_pg || busy !== m_pb || done !== 1'b0) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: got cyc=%0d gpio=%h done=%b busy=%b, expected no event",
                 tb_cyc, gpio, done, busy);
      end else begin
        x = sb_q.pop_front();
        if (x.cyc != tb_cyc || x.gpio !== gpio || x.done !== done || x.busy !== busy) begin
          n_err++;
          $display("FAIL event: got cyc=%0d gpio=%h done=%b busy=%b, expected cyc=%0d gpio=%h done=%b busy=%b",
                   tb_cyc, gpio, done, busy, x.cyc, x.gpio, x.done, x.busy);
        end
      end
    end
    m_pg = gpio;
    m_pb = busy;
    while (chk_name_q.size() > 0) begin
      string       nm;
      logic [63:0] a;
      logic [63:0] b;
      nm = chk_name_q.pop_front();
      a  = chk_act_q.pop_front();
      b  = chk_exp_q.pop_front();
      n_vec++;
      if (a !== b) begin
        n_err++;
        $display("FAIL %s: got %0h expected %0h", nm, a, b);
      end
    end
  end

  initial begin
    int e;
    int t0;
    nrst = 1'b0; en = 1'b0; stop = 1'b0; prescaler = '0;
    en2 = 1'b0; stop2 = 1'b0; prescaler2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({gpio, done, busy}), 64'(0));
    chk("reset_outputs_ms", 64'({gpio2, done2, busy2}), 64'(0));
    nrst = 1'b1;
    wait_cyc(tb_cyc + 2);

    // Full sweep at prescaler=1: done coincides with the return to bit 0.
    en = 1'b1; prescaler = 14'd1; e = tb_cyc + 1;
    push_sweep(e, 34);
    push(e + 136, oh(0), 1'b1, 1'b1);
    push(e + 139, '0, 1'b0, 1'b0);
    wait_cyc(e + 138); en = 1'b0;
    wait_cyc(e + 143);

    // stop held with en in IDLE: enter RUN, then pause 10 cycles.
    en = 1'b1; prescaler = 14'd1; stop = 1'b1; e = tb_cyc + 1;
    push(e, oh(0), 1'b0, 1'b1);
    push(e + 14, oh(1), 1'b0, 1'b1);
    push(e + 16, '0, 1'b0, 1'b0);
    wait_cyc(e + 10); stop = 1'b0;
    wait_cyc(e + 15); en = 1'b0;
    wait_cyc(e + 20);

    // prescaler=10 with a 25-cycle pause: first step moves from 40 to 65.
    en = 1'b1; prescaler = 14'd10; e = tb_cyc + 1;
    push(e, oh(0), 1'b0, 1'b1);
    push(e + 65, oh(1), 1'b0, 1'b1);
    push(e + 67, '0, 1'b0, 1'b0);
    wait_cyc(e + 19); stop = 1'b1;
    wait_cyc(e + 44); stop = 1'b0;
    wait_cyc(e + 66); en = 1'b0;
    wait_cyc(e + 72);

    // prescaler 1->3 during bit 5: bit 5 lasts 4 cycles, bits 6 and 7 last 12.
    en = 1'b1; prescaler = 14'd1; e = tb_cyc + 1;
    push_sweep(e, 6);
    push(e + 24, oh(6), 1'b0, 1'b1);
    push(e + 36, oh(7), 1'b0, 1'b1);
    push(e + 48, oh(8), 1'b0, 1'b1);
    push(e + 50, '0, 1'b0, 1'b0);
    wait_cyc(e + 21); prescaler = 14'd3;
    wait_cyc(e + 49); en = 1'b0;
    wait_cyc(e + 55);

    // en dropped on the wrapping step: IDLE, no done; then en with prescaler=0 stays IDLE.
    en = 1'b1; prescaler = 14'd1; e = tb_cyc + 1;
    push_sweep(e, 34);
    push(e + 136, '0, 1'b0, 1'b0);
    wait_cyc(e + 135); en = 1'b0;
    wait_cyc(e + 137); en = 1'b1; prescaler = '0;
    wait_cyc(e + 147);
    chk("idle_prescaler0", 64'({gpio, busy}), 64'(0));
    en = 1'b0;
    wait_cyc(e + 150);

    // prescaler=0 latched at the wrapping step: IDLE with no done.
    en = 1'b1; prescaler = 14'd1; e = tb_cyc + 1;
    push_sweep(e, 34);
    push(e + 136, '0, 1'b0, 1'b0);
    wait_cyc(e + 133); prescaler = '0;
    wait_cyc(e + 146); en = 1'b0;
    wait_cyc(e + 150);

    // Asynchronous reset between edges at bit 20, then restart from bit 0.
    en = 1'b1; prescaler = 14'd1; e = tb_cyc + 1;
    push_sweep(e, 21);
    push(e + 82, '0, 1'b0, 1'b0);
    push(e + 83, oh(0), 1'b0, 1'b1);
    push(e + 87, oh(1), 1'b0, 1'b1);
    push(e + 89, '0, 1'b0, 1'b0);
    wait_cyc(e + 82);
    #1 nrst = 1'b0;
    #1 chk("async_reset", 64'({gpio, done, busy}), 64'(0));
    #4 nrst = 1'b1;
    wait_cyc(e + 88); en = 1'b0;
    wait_cyc(e + 93);

    // Default 10000 cycles per ms: bit 0 to bit 1 is one millisecond.
    en2 = 1'b1; prescaler2 = 14'd1; e = tb_cyc + 1;
    for (int i = 0; i < 5 && gpio2[0] !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    t0 = tb_cyc;
    chk("ms_entry_cycle", 64'(t0), 64'(e));
    for (int i = 0; i < 20000 && gpio2[1] !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    chk("ms_interval", 64'(tb_cyc - t0), 64'(10000));
    chk("ms_bit1", 64'(gpio2), 64'(2));
    en2 = 1'b0;
    wait_cyc(tb_cyc + 3);
    chk("ms_idle", 64'({gpio2, busy2}), 64'(0));

    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drain", 64'(sb_q.size()), 64'(0));
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
